// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: shared types for the MemGen SRAM request sequencer.
// Holds default bus widths, the queued request bundle and the FSM states.
package mem_req_ctrl_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 16;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request/response handshakes plus SRAM macro pins.
// master = traffic source / macro model, slave = mem_req_ctrl.
interface mem_req_ctrl_if
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_chip_en;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_chip_en, mem_wr_en, mem_rd_en,
        input  mem_addr, mem_wr_data, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_chip_en, mem_wr_en, mem_rd_en,
        output mem_addr, mem_wr_data, init_done
    );

endinterface

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous FIFO, any depth >= 2, count-based full/empty.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i/data_o, full_o, empty_o.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues requests and drives a fixed-latency SRAM macro.
// Ports: clock, reset_n, bus (slave: req/rsp handshakes, mem pins, init_done).
// Optional init sweep (zero-fill) when MEMCTL_INIT_EN is defined.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int REQ_DEPTH = 4
) (
    input logic           clock,
    input logic           reset_n,
    mem_req_ctrl_if.slave bus
);

    localparam int RSP_DEPTH = RD_LAT + 2;
    localparam int CRED_W    = $clog2(RSP_DEPTH + 1);

    req_t              req_in, req_head;
    logic              req_full, req_empty, rsp_full, rsp_empty;
    logic              run, issue, rd_issue, rsp_pop;
    logic [DATA_W-1:0] rsp_data;

    state_t            state_q;
    logic              chip_en_q, wr_en_q, rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [CRED_W-1:0] cred_q, cred_d;

`ifdef MEMCTL_INIT_EN
    logic              init_done_q;
    logic [ADDR_W-1:0] init_addr_q;
    assign run           = init_done_q;
    assign bus.init_done = init_done_q;
`else
    assign run           = (state_q == RUN);
    assign bus.init_done = 1'b1;
`endif

    assign req_in = '{write: bus.req_write,
                      addr:  bus.req_addr,
                      wdata: bus.req_wdata};

    mem_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (bus.req_valid & bus.req_ready),
        .data_i  (req_in),
        .pop_i   (issue),
        .data_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty)
    );

    // Credits cover rsp FIFO slots plus reads in flight, so capture
    // into the response FIFO can never find it full.
    assign issue    = run & ~req_empty & (req_head.write | (cred_q != '0));
    assign rd_issue = issue & ~req_head.write;
    assign rsp_pop  = ~rsp_empty & bus.rsp_ready;

    always_comb begin
        cred_d = cred_q;
        if (rd_issue && !rsp_pop)      cred_d = cred_q - 1'b1;
        else if (!rd_issue && rsp_pop) cred_d = cred_q + 1'b1;
    end

    assign rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(rd_en_q);

    mem_req_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (rd_pipe_q[RD_LAT-1] & ~rsp_full),
        .data_i  (bus.mem_rd_data),
        .pop_i   (rsp_pop),
        .data_o  (rsp_data),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    assign bus.req_ready   = ~req_full & run;
    assign bus.rsp_valid   = ~rsp_empty;
    assign bus.rsp_rdata   = rsp_empty ? '0 : rsp_data;
    assign bus.mem_chip_en = chip_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cred_q    <= CRED_W'(RSP_DEPTH);
            rd_pipe_q <= '0;
        end else begin
            cred_q    <= cred_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT;
            chip_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef MEMCTL_INIT_EN
            init_addr_q <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            chip_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            unique case (state_q)
                INIT: begin
`ifdef MEMCTL_INIT_EN
                    chip_en_q   <= 1'b1;
                    wr_en_q     <= 1'b1;
                    addr_q      <= init_addr_q;
                    wdata_q     <= '0;
                    init_addr_q <= init_addr_q + 1'b1;
                    if (&init_addr_q) state_q <= RUN;
`else
                    state_q <= RUN;
`endif
                end
                RUN: begin
`ifdef MEMCTL_INIT_EN
                    // Lags RUN by one cycle: the last sweep write is on the pins.
                    init_done_q <= 1'b1;
`endif
                    if (issue) begin
                        chip_en_q <= 1'b1;
                        wr_en_q   <= req_head.write;
                        rd_en_q   <= ~req_head.write;
                        addr_q    <= req_head.addr;
                        if (req_head.write) wdata_q <= req_head.wdata;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed checks of mem_req_ctrl with a 1-cycle SRAM model.
// Default build (no init sweep), RD_LAT=1, REQ_DEPTH=4.
module tb_mem_req_ctrl;

    logic clock;
    logic reset_n;

    mem_req_ctrl_if bus ();

    mem_req_ctrl #(
        .ADDR_W    (10),
        .DATA_W    (16),
        .RD_LAT    (1),
        .REQ_DEPTH (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] tbmem [1024];
    logic [15:0] rsp_q [$];
    logic [9:0]  op_q  [$];
    int          rd_pulses;
    int          n_chk;
    int          n_pass;
    bit          acc8;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM macro model: data valid the cycle after rd_en.
    always @(posedge clock) begin
        if (bus.mem_chip_en && bus.mem_wr_en)
            tbmem[bus.mem_addr] = bus.mem_wr_data;
        if (bus.mem_chip_en && bus.mem_rd_en)
            bus.mem_rd_data <= tbmem[bus.mem_addr];
        if (bus.mem_rd_en) rd_pulses++;
        if (bus.mem_chip_en) op_q.push_back(bus.mem_addr);
        if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic w, input logic [9:0] a,
                        input logic [15:0] d);
        bit acc;
        acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clock);
            acc = bus.req_ready;
            step();
        end
        bus.req_valid = 1'b0;
        if (!acc) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input string tag, input int n);
        for (int i = 0; i < 80 && rsp_q.size() < n; i++) step();
        check(tag, rsp_q.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rd_pulses = 0;
        acc8 = 1'b0;
        for (int i = 0; i < 1024; i++) tbmem[i] = 16'h1000 ^ 16'(i);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.mem_rd_data = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;

        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_chip_en", bus.mem_chip_en, 0);
        check("rst_wr_en", bus.mem_wr_en, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_init_done", bus.init_done, 1);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_ready", bus.req_ready, 1);

        // Write then read 0x005.
        send(1'b1, 10'h005, 16'hBEEF);
        check("wr_a1_idle", bus.mem_chip_en, 0);
        step();
        check("wr_a2_chip_en", bus.mem_chip_en, 1);
        check("wr_a2_wr_en", bus.mem_wr_en, 1);
        check("wr_a2_rd_en", bus.mem_rd_en, 0);
        check("wr_a2_addr", bus.mem_addr, 10'h005);
        check("wr_a2_data", bus.mem_wr_data, 16'hBEEF);
        send(1'b0, 10'h005, 16'h0);
        check("rd_b1_idle", bus.mem_rd_en, 0);
        step();
        check("rd_b2_rd_en", bus.mem_rd_en, 1);
        check("rd_b2_wr_en", bus.mem_wr_en, 0);
        check("rd_b2_addr", bus.mem_addr, 10'h005);
        step();
        check("rd_b3_no_rsp", bus.rsp_valid, 0);
        step();
        check("rd_b4_rsp_valid", bus.rsp_valid, 1);
        check("rd_b4_rsp_data", bus.rsp_rdata, 16'hBEEF);
        step();
        check("rd_b5_rsp_popped", bus.rsp_valid, 0);

        // Backpressure and request-full.
        bus.rsp_ready = 1'b0;
        rsp_q.delete();
        rd_pulses = 0;
        for (int k = 0; k < 7; k++) send(1'b0, 10'h020 + 10'(k), 16'h0);
        repeat (6) step();
        check("bp_rd_pulses", rd_pulses, 3);
        check("full_ready_low", bus.req_ready, 0);
        fork
            begin
                send(1'b0, 10'h027, 16'h0);
                acc8 = 1'b1;
            end
        join_none
        repeat (5) step();
        check("full_5th_held", acc8, 0);
        check("bp_rd_pulses_hold", rd_pulses, 3);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        check("bp_rsp_head", bus.rsp_rdata, 16'h1020);
        bus.rsp_ready = 1'b1;
        wait_rsp("bp_rsp_count", 8);
        check("full_5th_accepted", acc8, 1);
        check("bp_rd_total", rd_pulses, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("bp_rsp_%0d", k), rsp_q[k], 16'h1020 + 16'(k));

        // Boundary addresses back-to-back.
        repeat (3) step();
        rsp_q.delete();
        op_q.delete();
        send(1'b1, 10'h000, 16'hFFFF);
        send(1'b1, 10'h3FF, 16'h0001);
        send(1'b0, 10'h000, 16'h0);
        send(1'b0, 10'h3FF, 16'h0);
        wait_rsp("bnd_rsp_count", 2);
        check("bnd_rsp_0", rsp_q[0], 16'hFFFF);
        check("bnd_rsp_3ff", rsp_q[1], 16'h0001);
        check("bnd_op_count", op_q.size(), 4);
        check("bnd_op0_addr", op_q[0], 10'h000);
        check("bnd_op1_addr", op_q[1], 10'h3FF);
        check("bnd_op2_addr", op_q[2], 10'h000);
        check("bnd_op3_addr", op_q[3], 10'h3FF);

        // Reset with two reads in flight.
        repeat (3) step();
        send(1'b0, 10'h040, 16'h0);
        send(1'b0, 10'h041, 16'h0);
        #2 reset_n = 1'b0;
        rsp_q.delete();
        #1;
        check("mid_rst_chip_en", bus.mem_chip_en, 0);
        check("mid_rst_rd_en", bus.mem_rd_en, 0);
        check("mid_rst_wr_en", bus.mem_wr_en, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) step();
        check("post_rst2_ready", bus.req_ready, 1);
        check("no_stale_rsp", rsp_q.size(), 0);
        check("no_stale_valid", bus.rsp_valid, 0);

        // Credits back at RD_LAT+2 after reset.
        bus.rsp_ready = 1'b0;
        rd_pulses = 0;
        for (int k = 0; k < 4; k++) send(1'b0, 10'h050 + 10'(k), 16'h0);
        repeat (6) step();
        check("cred_rd_pulses", rd_pulses, 3);
        bus.rsp_ready = 1'b1;
        wait_rsp("cred_rsp_count", 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("cred_rsp_%0d", k), rsp_q[k], 16'h1050 + 16'(k));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request sequencer directly upstream of the 16x1024 MemGen SRAM macro.
- Accepts valid/ready read/write requests, queues them, and drives the macro's chip_en/wr_en/rd_en/addr/wr_data pins from flops.
- Captures rd_data after the macro's fixed read latency and returns responses in order, with backpressure on the response side.

Parameters:
- ADDR_W, 10, memory address width (depth = 2**ADDR_W).
- DATA_W, 16, data width.
- RD_LAT, 1, cycles from the mem_rd_en-high cycle to the cycle in which mem_rd_data is valid (>=1).
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data.
- mem_chip_en  out  1  to macro chip_en.
- mem_wr_en  out  1  to macro wr_en.
- mem_rd_en  out  1  to macro rd_en.
- mem_addr  out  ADDR_W  to macro addr.
- mem_wr_data  out  DATA_W  to macro wr_data.
- mem_rd_data  in  DATA_W  from macro rd_data.
- init_done  out  1  controller ready for traffic.

Behaviour:
- Reset: clock is single; reset_n is asynchronous, active-low. While reset_n=0, all outputs are 0 except init_done (see Optional Feature).
- Reset also clears both FIFOs, the credit counter and the in-flight pipe. In-flight reads at reset are dropped; no response is produced for them.
- Request FIFO: req_ready = !req_fifo_full & init_done.
- Issue stage: at most one operation per cycle. The FIFO head pops when it is a write, or when it is a read and credits > 0.
- On pop, the issue flops load mem_chip_en=1, mem_wr_en=write, mem_rd_en=!write, mem_addr, and mem_wr_data (wdata for writes, held for reads).
- With no pop, mem_chip_en, mem_wr_en and mem_rd_en are 0. mem_addr and mem_wr_data hold their last values.
- Idle latency: request accepted in cycle a -> mem_*_en high in cycle a+2.
- Read return: an RD_LAT-deep valid shift register tracks reads. mem_rd_data is captured at the end of cycle (rd_en cycle + RD_LAT) into the response FIFO. With RD_LAT=1, rsp_valid rises in cycle a+4.
- Response FIFO: depth RD_LAT+2. It holds rsp_valid/rsp_rdata stable until rsp_ready.
- Credits:
  - Reset value RD_LAT+2.
  - Decrement on read issue; increment on response pop; both in the same cycle leave it unchanged.
  - The response FIFO can never overflow and no captured data is ever lost.
- Ordering: strict program order. A write followed by a read to the same address returns the new data. Responses return in read-issue order.
- Full FIFO: req_ready=0. Simultaneous push+pop on a full FIFO is not allowed, because ready is computed from the registered full flag.
- Empty FIFO: no issue. Pointers wrap modulo REQ_DEPTH.
- FSM states:
  - INIT -> RUN when the init sweep ends, or immediately after reset when the Optional Feature is off.
  - RUN is terminal until reset.

Optional Feature:
- Macro: MEMCTL_INIT_EN.
- Defined:
  - After reset release, INIT writes DATA_W'0 to addresses 0..2**ADDR_W-1, one per cycle, with mem_chip_en=mem_wr_en=1.
  - req_ready=0 and init_done=0 throughout. init_done=1 the cycle after the last write.
  - Reset mid-sweep restarts the sweep at address 0.
- Undefined: no INIT state, and init_done is constant 1, including during reset.

Decomposition:
- Package mem_req_ctrl_pkg holds:
  - Default ADDR_W/DATA_W localparams.
  - A packed req_t {write, addr, wdata} typedef.
  - A state_t enum {INIT, RUN}.
- One generic sub-module, mem_req_fifo (parameterised width/depth sync FIFO with full/empty), instantiated for both the request queue and the response queue.

Test Plan:
- Single write then read: write addr 0x005 data 0xBEEF, read 0x005 -> mem_wr_en high in cycle a+2; rsp_rdata=0xBEEF; rsp_valid rises 4 cycles after the read's acceptance (RD_LAT=1).
- Backpressure: hold rsp_ready=0 and issue 8 reads -> exactly RD_LAT+2 mem_rd_en pulses, then reads stall. Release rsp_ready -> all 8 responses return in order, none lost.
- Request full: stall issue via credits and push 5 requests at REQ_DEPTH=4 -> req_ready=0 after the 4th is accepted; the 5th is accepted once a pop occurs.
- Boundary addresses: write/read 0x000 and 0x3FF back-to-back with 0xFFFF/0x0001 -> correct data, and mem_addr is not corrupted at wrap.
- Reset mid-operation: assert reset_n=0 with 2 reads in flight -> all mem_*_en, rsp_valid and req_ready are 0 immediately. After release, no stale responses and credits=RD_LAT+2.
- With MEMCTL_INIT_EN: after reset -> 1024 consecutive zero writes, init_done rises at cycle 1025, and a read of 0x3FF returns 0x0000.
